// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction-fetch front end with a small in-order fetch queue.
//
// The block issues sequential fetch addresses to a variable-latency
// instruction memory using a req/gnt/rvalid handshake. Each granted request
// allocates a queue entry that holds the request pc. The entry is marked
// filled when its in-order response returns. The head entry is presented to
// decode with valid/ready back-pressure.
//
// A redirect flushes every entry and restarts fetch at the target. Responses
// that are still owed for flushed requests are counted in a discard counter
// and dropped as they arrive.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   redirect_valid/_pc    flush queue and restart fetch at redirect_pc & ~3
//   imem_req/_addr        fetch request and its address (current pc)
//   imem_gnt              memory accepts the request this cycle
//   imem_rvalid/_rdata    in-order instruction response
//   out_valid/_ready      head handshake towards decode
//   out_pc/_pc4/_instr    head pc, pc+4 and instruction word (0 when empty)
//   occupancy             allocated entries (filled + waiting for response)
//   err                   sticky: a response arrived with nothing owed
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic                       imem_gnt,
    input  logic                       imem_rvalid,
    input  logic [31:0]                imem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_pc4,
    output logic [31:0]                out_instr,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_CW = (CW + 1)'(DEPTH);

    // Entry storage. Data fields are not reset; the filled flags and the
    // pointers/counters below decide what is meaningful.
    logic [XLEN-1:0]  ent_pc_q    [DEPTH];
    logic [XLEN-1:0]  ent_pc_d    [DEPTH];
    logic [31:0]      ent_instr_q [DEPTH];
    logic [31:0]      ent_instr_d [DEPTH];
    logic [DEPTH-1:0] ent_filled_q, ent_filled_d;

    logic [PW-1:0]    alloc_ptr_q, alloc_ptr_d;
    logic [PW-1:0]    fill_ptr_q,  fill_ptr_d;
    logic [PW-1:0]    head_ptr_q,  head_ptr_d;
    logic [CW-1:0]    count_q,     count_d;
    logic [CW-1:0]    unfilled_q,  unfilled_d;
    logic [CW-1:0]    discard_q,   discard_d;
    logic [XLEN-1:0]  pc_q,        pc_d;
    logic             err_q,       err_d;

    logic             head_filled;
    logic             nonempty;
    logic             issue_ok;
    logic [CW:0]      in_flight;
    logic             do_issue;
    logic             do_pop;
    logic             resp_drop;
    logic             resp_fill;
    logic             resp_spur;

    // Outputs towards memory and decode
    always_comb begin
        // Keep allocated entries plus still-owed discarded responses within
        // DEPTH. This bounds the discard counter to DEPTH after any redirect
        // sequence.
        in_flight   = {1'b0, count_q} + {1'b0, discard_q};
        issue_ok    = (count_q < DEPTH_C) && (in_flight < DEPTH_CW);
        imem_req    = !reset && !redirect_valid && issue_ok;
        imem_addr   = pc_q;

        head_filled = ent_filled_q[head_ptr_q];
        nonempty    = !reset && (count_q != '0);
        out_valid   = !reset && head_filled && !redirect_valid;
        out_pc      = nonempty ? ent_pc_q[head_ptr_q] : '0;
        out_pc4     = nonempty ? (ent_pc_q[head_ptr_q] + XLEN'(4)) : '0;
        out_instr   = (nonempty && head_filled) ? ent_instr_q[head_ptr_q] : '0;
        occupancy   = reset ? '0 : count_q;
        err         = err_q;
    end

    // Next-state logic
    always_comb begin
        do_issue  = imem_req && imem_gnt;
        do_pop    = out_valid && out_ready;
        resp_drop = imem_rvalid && (discard_q != '0);
        resp_fill = imem_rvalid && (discard_q == '0) && (unfilled_q != '0);
        resp_spur = imem_rvalid && (discard_q == '0) && (unfilled_q == '0);

        ent_pc_d     = ent_pc_q;
        ent_instr_d  = ent_instr_q;
        ent_filled_d = ent_filled_q;
        alloc_ptr_d  = alloc_ptr_q;
        fill_ptr_d   = fill_ptr_q;
        head_ptr_d   = head_ptr_q;
        count_d      = count_q;
        unfilled_d   = unfilled_q;
        discard_d    = discard_q;
        pc_d         = pc_q;
        err_d        = err_q | resp_spur;

        if (redirect_valid) begin
            // Every request still waiting for its response becomes a
            // response to throw away. A response arriving right now
            // settles one of those debts immediately.
            pc_d         = redirect_pc & ~XLEN'(3);
            ent_filled_d = '0;
            alloc_ptr_d  = '0;
            fill_ptr_d   = '0;
            head_ptr_d   = '0;
            count_d      = '0;
            unfilled_d   = '0;
            discard_d    = discard_q + unfilled_q - CW'(resp_drop || resp_fill);
        end else begin
            // Issue, fill and pop always touch different entries: issue
            // needs a free slot, fill targets an unfilled slot, and pop
            // takes a filled one.
            if (do_issue) begin
                ent_pc_d[alloc_ptr_q]     = pc_q;
                ent_filled_d[alloc_ptr_q] = 1'b0;
                alloc_ptr_d               = alloc_ptr_q + PW'(1);
                pc_d                      = pc_q + XLEN'(4);
            end
            if (resp_fill) begin
                ent_instr_d[fill_ptr_q]  = imem_rdata;
                ent_filled_d[fill_ptr_q] = 1'b1;
                fill_ptr_d               = fill_ptr_q + PW'(1);
            end
            if (do_pop) begin
                ent_filled_d[head_ptr_q] = 1'b0;
                head_ptr_d               = head_ptr_q + PW'(1);
            end
            count_d    = count_q + CW'(do_issue) - CW'(do_pop);
            unfilled_d = unfilled_q + CW'(do_issue) - CW'(resp_fill);
            discard_d  = discard_q - CW'(resp_drop);
        end
    end

    // Control state
    always_ff @(posedge clk) begin
        if (reset) begin
            ent_filled_q <= '0;
            alloc_ptr_q  <= '0;
            fill_ptr_q   <= '0;
            head_ptr_q   <= '0;
            count_q      <= '0;
            unfilled_q   <= '0;
            discard_q    <= '0;
            pc_q         <= RESET_PC;
            err_q        <= 1'b0;
        end else begin
            ent_filled_q <= ent_filled_d;
            alloc_ptr_q  <= alloc_ptr_d;
            fill_ptr_q   <= fill_ptr_d;
            head_ptr_q   <= head_ptr_d;
            count_q      <= count_d;
            unfilled_q   <= unfilled_d;
            discard_q    <= discard_d;
            pc_q         <= pc_d;
            err_q        <= err_d;
        end
    end

    // Entry payload
    always_ff @(posedge clk) begin
        ent_pc_q    <= ent_pc_d;
        ent_instr_q <= ent_instr_d;
    end

endmodule
